pma_checker: RTL and testbench

Parametrised, programmable physical-memory-attribute checker replacing the fixed DRAM/ROM/IO decode. It holds N_REGIONS base/mask/attribute entries and answers pipelined lookups with a matched region, attributes and an access fault. Software programs entries through a config write port, with optional per-entry lock. It sits between the TLB/PTW physical-address output and the fetch/LSU request paths.

---
 rtl/pma_checker.sv | 169 ++++++++++++++++
 tb/tb_pma_checker.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pma_checker.sv
// pma_checker: programmable physical-memory-attribute checker.
// Holds N_REGIONS base/mask/attribute entries, answers lookups through a single
// registered response stage and accepts config writes with a per-entry lock.
// Optional build macro PMA_CHECKER_FAULT_COUNT_EN adds a saturating 16-bit
// count of faulting responses that completed a handshake.
module pma_checker #(
    parameter int N_REGIONS  = 8,
    parameter int ATTR_WIDTH = 5,
    parameter int PPN_WIDTH  = 22
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [PPN_WIDTH-1:0]         req_PPN,
    input  logic [1:0]                   req_acc,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [N_REGIONS-1:0]         resp_hit_onehot,
    output logic [ATTR_WIDTH-1:0]        resp_attr,
    output logic                         resp_fault,
    input  logic                         cfg_wr_valid,
    input  logic [$clog2(N_REGIONS)-1:0] cfg_idx,
    input  logic [PPN_WIDTH-1:0]         cfg_base,
    input  logic [PPN_WIDTH-1:0]         cfg_mask,
    input  logic [ATTR_WIDTH-1:0]        cfg_attr,
    input  logic                         cfg_en,
    input  logic                         cfg_lock
`ifdef PMA_CHECKER_FAULT_COUNT_EN
    ,
    output logic [15:0]                  fault_count
`endif
);

    // Attribute bit positions within an entry
    localparam int ATTR_R = 0;
    localparam int ATTR_W = 1;
    localparam int ATTR_X = 2;

    // Power-on map: DRAM, boot ROM and IO window
    localparam logic [PPN_WIDTH-1:0]  DRAM_BASE = PPN_WIDTH'(22'h380000);
    localparam logic [PPN_WIDTH-1:0]  DRAM_MASK = PPN_WIDTH'(22'h380000);
    localparam logic [ATTR_WIDTH-1:0] DRAM_ATTR = ATTR_WIDTH'(5'b11111);
    localparam logic [PPN_WIDTH-1:0]  ROM_BASE  = PPN_WIDTH'(22'h000010);
    localparam logic [PPN_WIDTH-1:0]  ROM_MASK  = PPN_WIDTH'(22'h3FFFF0);
    localparam logic [ATTR_WIDTH-1:0] ROM_ATTR  = ATTR_WIDTH'(5'b11101);
    localparam logic [PPN_WIDTH-1:0]  IO_BASE   = PPN_WIDTH'(22'h000000);
    localparam logic [PPN_WIDTH-1:0]  IO_MASK   = PPN_WIDTH'(22'h3FFFF0);
    localparam logic [ATTR_WIDTH-1:0] IO_ATTR   = ATTR_WIDTH'(5'b00011);

    // Region table
    logic [PPN_WIDTH-1:0]  base_q [N_REGIONS];
    logic [PPN_WIDTH-1:0]  mask_q [N_REGIONS];
    logic [ATTR_WIDTH-1:0] attr_q [N_REGIONS];
    logic [N_REGIONS-1:0]  en_q;
    logic [N_REGIONS-1:0]  lock_q;

    // Lookup datapath
    logic [N_REGIONS-1:0]  match_vec;
    logic [N_REGIONS-1:0]  hit_onehot;
    logic [ATTR_WIDTH-1:0] hit_attr;
    logic                  hit_found;
    logic                  access_ok;
    logic                  lookup_fault;

    logic idx_in_range;
    logic cfg_write_go;
    logic req_fire;

    assign idx_in_range = (int'(cfg_idx) < N_REGIONS);
    assign cfg_write_go = cfg_wr_valid && idx_in_range && !lock_q[cfg_idx];
    assign req_ready    = !resp_valid || resp_ready;
    assign req_fire     = req_valid && req_ready;

    // Region table: reset map, then software writes to unlocked entries only.
    // Lookups read the registered table, so a write lands after a same-cycle lookup.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < N_REGIONS; i++) begin
                base_q[i] <= '0;
                mask_q[i] <= '0;
                attr_q[i] <= '0;
            end
            en_q      <= '0;
            lock_q    <= '0;
            base_q[0] <= DRAM_BASE;
            mask_q[0] <= DRAM_MASK;
            attr_q[0] <= DRAM_ATTR;
            en_q[0]   <= 1'b1;
            base_q[1] <= ROM_BASE;
            mask_q[1] <= ROM_MASK;
            attr_q[1] <= ROM_ATTR;
            en_q[1]   <= 1'b1;
            base_q[2] <= IO_BASE;
            mask_q[2] <= IO_MASK;
            attr_q[2] <= IO_ATTR;
            en_q[2]   <= 1'b1;
        end else if (cfg_write_go) begin
            base_q[cfg_idx] <= cfg_base;
            mask_q[cfg_idx] <= cfg_mask;
            attr_q[cfg_idx] <= cfg_attr;
            en_q[cfg_idx]   <= cfg_en;
            lock_q[cfg_idx] <= cfg_lock;
        end
    end

    // Per-entry masked compare against the requested page number
    always_comb begin
        match_vec = '0;
        for (int i = 0; i < N_REGIONS; i++) begin
            match_vec[i] = en_q[i] && ((req_PPN & mask_q[i]) == (base_q[i] & mask_q[i]));
        end
    end

    // Lowest-index matching entry wins and supplies the attributes
    always_comb begin
        hit_onehot = '0;
        hit_attr   = '0;
        hit_found  = 1'b0;
        for (int i = 0; i < N_REGIONS; i++) begin
            if (match_vec[i] && !hit_found) begin
                hit_onehot[i] = 1'b1;
                hit_attr      = attr_q[i];
                hit_found     = 1'b1;
            end
        end
    end

    // Permission check by access type; the reserved encoding is never allowed
    always_comb begin
        access_ok = 1'b0;
        case (req_acc)
            2'b00:   access_ok = hit_attr[ATTR_R];
            2'b01:   access_ok = hit_attr[ATTR_W];
            2'b10:   access_ok = hit_attr[ATTR_X];
            default: access_ok = 1'b0;
        endcase
        lookup_fault = !hit_found || !access_ok;
    end

    // Response stage: load on accept, hold under backpressure, retire on handshake
    always_ff @(posedge CLK) begin
        if (RST) begin
            resp_valid      <= 1'b0;
            resp_hit_onehot <= '0;
            resp_attr       <= '0;
            resp_fault      <= 1'b0;
        end else if (req_fire) begin
            resp_valid      <= 1'b1;
            resp_hit_onehot <= hit_onehot;
            resp_attr       <= hit_attr;
            resp_fault      <= lookup_fault;
        end else if (resp_ready) begin
            resp_valid      <= 1'b0;
        end
    end

`ifdef PMA_CHECKER_FAULT_COUNT_EN
    // Saturating count of faulting responses taken by the consumer
    always_ff @(posedge CLK) begin
        if (RST) begin
            fault_count <= '0;
        end else if (resp_valid && resp_ready && resp_fault && (fault_count != 16'hFFFF)) begin
            fault_count <= fault_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pma_checker.sv
// tb_pma_checker: directed, table-driven bench for pma_checker.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_pma_checker;

    localparam int NR = 8;
    localparam int AW = 5;
    localparam int PW = 22;

    logic          CLK;
    logic          RST;
    logic          req_valid;
    logic          req_ready;
    logic [PW-1:0] req_PPN;
    logic [1:0]    req_acc;
    logic          resp_valid;
    logic          resp_ready;
    logic [NR-1:0] resp_hit_onehot;
    logic [AW-1:0] resp_attr;
    logic          resp_fault;
    logic          cfg_wr_valid;
    logic [2:0]    cfg_idx;
    logic [PW-1:0] cfg_base;
    logic [PW-1:0] cfg_mask;
    logic [AW-1:0] cfg_attr;
    logic          cfg_en;
    logic          cfg_lock;
`ifdef PMA_CHECKER_FAULT_COUNT_EN
    logic [15:0]   fault_count;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        string         name;
        logic [1:0]    acc;
        logic [PW-1:0] ppn;
        logic [NR-1:0] hit;
        logic [AW-1:0] attr;
        logic          fault;
    } vec_t;

    vec_t vecs[10];

    pma_checker #(.N_REGIONS(NR), .ATTR_WIDTH(AW), .PPN_WIDTH(PW)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_PPN         (req_PPN),
        .req_acc         (req_acc),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_hit_onehot (resp_hit_onehot),
        .resp_attr       (resp_attr),
        .resp_fault      (resp_fault),
        .cfg_wr_valid    (cfg_wr_valid),
        .cfg_idx         (cfg_idx),
        .cfg_base        (cfg_base),
        .cfg_mask        (cfg_mask),
        .cfg_attr        (cfg_attr),
        .cfg_en          (cfg_en),
        .cfg_lock        (cfg_lock)
`ifdef PMA_CHECKER_FAULT_COUNT_EN
        ,
        .fault_count     (fault_count)
`endif
    );

    // Free-running clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] acc, input logic [PW-1:0] ppn);
        @(negedge CLK);
        req_valid = v;
        req_acc   = acc;
        req_PPN   = ppn;
    endtask

    task automatic setCfg(input logic wr, input logic [2:0] idx, input logic [PW-1:0] base,
                          input logic [PW-1:0] mask, input logic [AW-1:0] attr,
                          input logic en, input logic lock);
        cfg_wr_valid = wr;
        cfg_idx      = idx;
        cfg_base     = base;
        cfg_mask     = mask;
        cfg_attr     = attr;
        cfg_en       = en;
        cfg_lock     = lock;
    endtask

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string name, input logic ev, input logic chk_data,
                               input logic [NR-1:0] ehit, input logic [AW-1:0] eattr, input logic efault);
        checkValue({name, ".valid"}, 32'(resp_valid), 32'(ev));
        if (chk_data) begin
            checkValue({name, ".hit"},   32'(resp_hit_onehot), 32'(ehit));
            checkValue({name, ".attr"},  32'(resp_attr),       32'(eattr));
            checkValue({name, ".fault"}, 32'(resp_fault),      32'(efault));
        end
    endtask

    task automatic checkCount(input string name, input logic [15:0] expected);
`ifdef PMA_CHECKER_FAULT_COUNT_EN
        checkValue(name, 32'(fault_count), 32'(expected));
`else
        if (expected === 16'hxxxx) $display("[TB] %s unused", name);
`endif
    endtask

    initial begin
        // Lookups against the reset map; accesses: 00 R, 01 W, 10 X, 11 reserved
        vecs[0] = '{"dram_rd",     2'b00, 22'h380005, 8'h01, 5'b11111, 1'b0};
        vecs[1] = '{"rom_wr",      2'b01, 22'h000012, 8'h02, 5'b11101, 1'b1};
        vecs[2] = '{"io_x",        2'b10, 22'h000003, 8'h04, 5'b00011, 1'b1};
        vecs[3] = '{"io_rd",       2'b00, 22'h000003, 8'h04, 5'b00011, 1'b0};
        vecs[4] = '{"io_wr",       2'b01, 22'h00000F, 8'h04, 5'b00011, 1'b0};
        vecs[5] = '{"rom_x",       2'b10, 22'h000015, 8'h02, 5'b11101, 1'b0};
        vecs[6] = '{"dram_rsvd",   2'b11, 22'h380000, 8'h01, 5'b11111, 1'b1};
        vecs[7] = '{"miss_100001", 2'b00, 22'h100001, 8'h00, 5'b00000, 1'b1};
        vecs[8] = '{"dram_top",    2'b01, 22'h3FFFFF, 8'h01, 5'b11111, 1'b0};
        vecs[9] = '{"miss_20",     2'b10, 22'h000020, 8'h00, 5'b00000, 1'b1};

        RST = 1'b1;
        resp_ready = 1'b1;
        req_valid = 1'b0;
        req_acc = 2'b00;
        req_PPN = '0;
        setCfg(1'b0, 3'd0, '0, '0, '0, 1'b0, 1'b0);

        // Reset holds the response stage empty even with a request pending
        applyStimulus(1'b1, 2'b00, 22'h380005);
        RST = 1'b1;
        tick();
        checkOutput("reset0", 1'b0, 1'b1, 8'h00, 5'b00000, 1'b0);
        checkValue("reset0.req_ready", 32'(req_ready), 32'd1);
        checkCount("reset0.count", 16'd0);
        tick();
        checkOutput("reset1", 1'b0, 1'b1, 8'h00, 5'b00000, 1'b0);

        // Back-to-back table lookups, one per cycle
        @(negedge CLK);
        RST = 1'b0;
        req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, vecs[i].acc, vecs[i].ppn);
            tick();
            checkOutput(vecs[i].name, 1'b1, 1'b1, vecs[i].hit, vecs[i].attr, vecs[i].fault);
        end
        applyStimulus(1'b0, 2'b00, '0);
        tick();
        checkOutput("retire", 1'b0, 1'b0, '0, '0, 1'b0);

        // Config write in the same cycle as a lookup: lookup sees old table
        applyStimulus(1'b1, 2'b00, 22'h100001);
        setCfg(1'b1, 3'd5, 22'h100000, 22'h3F0000, 5'b00111, 1'b1, 1'b0);
        tick();
        checkOutput("collide_pre", 1'b1, 1'b1, 8'h00, 5'b00000, 1'b1);
        applyStimulus(1'b1, 2'b00, 22'h100001);
        setCfg(1'b0, 3'd0, '0, '0, '0, 1'b0, 1'b0);
        tick();
        checkOutput("collide_post", 1'b1, 1'b1, 8'h20, 5'b00111, 1'b0);

        // Lock entry 5, then try to disable it
        applyStimulus(1'b0, 2'b00, '0);
        setCfg(1'b1, 3'd5, 22'h100000, 22'h3F0000, 5'b00111, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 2'b00, '0);
        setCfg(1'b1, 3'd5, 22'h000000, 22'h000000, 5'b00000, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 2'b00, 22'h100001);
        setCfg(1'b0, 3'd0, '0, '0, '0, 1'b0, 1'b0);
        tick();
        checkOutput("locked_hit", 1'b1, 1'b1, 8'h20, 5'b00111, 1'b0);

        // Reset discards the in-flight response and restores entry 5
        @(negedge CLK);
        RST = 1'b1;
        req_valid = 1'b0;
        resp_ready = 1'b0;
        tick();
        checkOutput("reset_flush", 1'b0, 1'b1, 8'h00, 5'b00000, 1'b0);
        checkValue("reset_flush.req_ready", 32'(req_ready), 32'd1);
        @(negedge CLK);
        RST = 1'b0;
        resp_ready = 1'b1;
        applyStimulus(1'b1, 2'b00, 22'h100001);
        tick();
        checkOutput("post_reset_miss", 1'b1, 1'b1, 8'h00, 5'b00000, 1'b1);

        // Overlapping entry 3 loses to entry 0 until entry 0 is disabled
        applyStimulus(1'b0, 2'b00, '0);
        setCfg(1'b1, 3'd3, 22'h380000, 22'h380000, 5'b00001, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 2'b01, 22'h380000);
        setCfg(1'b0, 3'd0, '0, '0, '0, 1'b0, 1'b0);
        tick();
        checkOutput("overlap_prio", 1'b1, 1'b1, 8'h01, 5'b11111, 1'b0);
        applyStimulus(1'b0, 2'b00, '0);
        setCfg(1'b1, 3'd0, 22'h380000, 22'h380000, 5'b11111, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 2'b01, 22'h380000);
        setCfg(1'b0, 3'd0, '0, '0, '0, 1'b0, 1'b0);
        tick();
        checkOutput("overlap_e3_wr", 1'b1, 1'b1, 8'h08, 5'b00001, 1'b1);
        applyStimulus(1'b1, 2'b00, 22'h380000);
        tick();
        checkOutput("overlap_e3_rd", 1'b1, 1'b1, 8'h08, 5'b00001, 1'b0);

        // Backpressure with a faulting response, starting from a clean reset
        @(negedge CLK);
        RST = 1'b1;
        req_valid = 1'b0;
        tick();
        @(negedge CLK);
        RST = 1'b0;
        resp_ready = 1'b0;
        req_valid = 1'b1;
        req_acc = 2'b10;
        req_PPN = 22'h000003;
        tick();
        checkOutput("bp_first", 1'b1, 1'b1, 8'h04, 5'b00011, 1'b1);
        checkCount("bp_first.count", 16'd0);
        applyStimulus(1'b1, 2'b00, 22'h380005);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput($sformatf("bp_hold%0d", k), 1'b1, 1'b1, 8'h04, 5'b00011, 1'b1);
            checkValue($sformatf("bp_hold%0d.req_ready", k), 32'(req_ready), 32'd0);
            checkCount($sformatf("bp_hold%0d.count", k), 16'd0);
        end
        @(negedge CLK);
        resp_ready = 1'b1;
        #1;
        checkValue("bp_release.req_ready", 32'(req_ready), 32'd1);
        tick();
        checkOutput("bp_second", 1'b1, 1'b1, 8'h01, 5'b11111, 1'b0);
        checkCount("bp_second.count", 16'd1);
        applyStimulus(1'b1, 2'b11, 22'h000003);
        tick();
        checkOutput("bp_third", 1'b1, 1'b1, 8'h04, 5'b00011, 1'b1);
        checkCount("bp_third.count", 16'd1);
        applyStimulus(1'b0, 2'b00, '0);
        tick();
        checkOutput("bp_drain", 1'b0, 1'b0, '0, '0, 1'b0);
        checkCount("bp_drain.count", 16'd2);
        tick();
        checkCount("bp_idle.count", 16'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
